// File: rtl/quad_step_decoder.sv
// Quadrature step decoder: synchronizes and glitch-filters raw A/B pins, then emits step/direction/error pulses.
// Define QDEC_POSITION_EN to add a wrapping up/down position register fed by the step pulses.
module quad_step_decoder #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 3,
  parameter int POS_WIDTH   = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 quad_a,
  input  logic                 quad_b,
  output logic                 up_down,
  output logic                 enable,
  output logic                 error,
  output logic                 primed
`ifdef QDEC_POSITION_EN
  ,
  output logic [POS_WIDTH-1:0] position
`endif
);

  localparam int CW = $clog2(FILTER_LEN + 1);

  typedef enum logic {ST_UNPRIMED, ST_TRACK} state_t;

  if (SYNC_STAGES < 2 || FILTER_LEN < 1 || POS_WIDTH < 1) begin : g_param_check
    $error("quad_step_decoder: illegal parameter value");
  end

  // {from,to} pairs of the A-leads-B sequence 00->10->11->01->00
  function automatic logic step_is_up(input logic [1:0] from_ab, input logic [1:0] to_ab);
    case ({from_ab, to_ab})
      4'b0010, 4'b1011, 4'b1101, 4'b0100: step_is_up = 1'b1;
      default:                            step_is_up = 1'b0;
    endcase
  endfunction

  logic [SYNC_STAGES-1:0] sync_a_q, sync_b_q, sync_vld_q;
  logic [1:0]             synced;
  logic [1:0][CW-1:0]     cnt_q, cnt_d;
  logic [1:0]             filt_q, filt_d;
  logic [1:0]             fvld_q, fvld_d;
  logic [CW-1:0]          cnt_nxt;

  state_t                 state_q, state_d;
  logic [1:0]             prev_q, prev_d;
  logic [1:0]             delta;
  logic                   primed_q, primed_d;
  logic                   up_q, up_d;
  logic                   en_q, en_d;
  logic                   err_q, err_d;

  // sync_vld_q marks when the chain holds real pin samples again after reset
  always_ff @(posedge clock) begin
    if (reset) begin
      sync_a_q   <= '0;
      sync_b_q   <= '0;
      sync_vld_q <= '0;
    end else begin
      sync_a_q   <= {sync_a_q[SYNC_STAGES-2:0], quad_a};
      sync_b_q   <= {sync_b_q[SYNC_STAGES-2:0], quad_b};
      sync_vld_q <= {sync_vld_q[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign synced = {sync_a_q[SYNC_STAGES-1], sync_b_q[SYNC_STAGES-1]};

  // Before a channel is valid the counter measures a run of identical samples from scratch;
  // afterwards it measures how long the sample has disagreed with the filtered level.
  always_comb begin
    cnt_d   = cnt_q;
    filt_d  = filt_q;
    fvld_d  = fvld_q;
    cnt_nxt = '0;
    if (sync_vld_q[SYNC_STAGES-1]) begin
      for (int i = 0; i < 2; i++) begin
        if (!fvld_q[i]) begin
          cnt_nxt   = (synced[i] == filt_q[i]) ? cnt_q[i] + 1'b1 : CW'(1);
          filt_d[i] = synced[i];
          if (cnt_nxt == CW'(FILTER_LEN)) begin
            fvld_d[i] = 1'b1;
            cnt_d[i]  = '0;
          end else begin
            cnt_d[i] = cnt_nxt;
          end
        end else if (synced[i] == filt_q[i]) begin
          cnt_d[i] = '0;
        end else begin
          cnt_nxt = cnt_q[i] + 1'b1;
          if (cnt_nxt == CW'(FILTER_LEN)) begin
            filt_d[i] = synced[i];
            cnt_d[i]  = '0;
          end else begin
            cnt_d[i] = cnt_nxt;
          end
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q  <= '0;
      filt_q <= '0;
      fvld_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      filt_q <= filt_d;
      fvld_q <= fvld_d;
    end
  end

  assign delta = filt_q ^ prev_q;

  // Priming uses the filter's next state so primed rises with the last accepted sample.
  always_comb begin
    state_d  = state_q;
    prev_d   = prev_q;
    primed_d = primed_q;
    up_d     = up_q;
    en_d     = 1'b0;
    err_d    = 1'b0;
    case (state_q)
      ST_UNPRIMED: begin
        if (&fvld_d) begin
          prev_d   = filt_d;
          primed_d = 1'b1;
          state_d  = ST_TRACK;
        end
      end
      ST_TRACK: begin
        if (delta == 2'b11) begin
          err_d  = 1'b1;
          prev_d = filt_q;
        end else if (delta != 2'b00) begin
          en_d   = 1'b1;
          up_d   = step_is_up(prev_q, filt_q);
          prev_d = filt_q;
        end
      end
      default: state_d = ST_UNPRIMED;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ST_UNPRIMED;
      prev_q   <= '0;
      primed_q <= 1'b0;
      up_q     <= 1'b0;
      en_q     <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      prev_q   <= prev_d;
      primed_q <= primed_d;
      up_q     <= up_d;
      en_q     <= en_d;
      err_q    <= err_d;
    end
  end

  assign up_down = up_q;
  assign enable  = en_q;
  assign error   = err_q;
  assign primed  = primed_q;

`ifdef QDEC_POSITION_EN
  logic [POS_WIDTH-1:0] pos_q, pos_d;

  always_comb begin
    pos_d = pos_q;
    if (en_q) begin
      pos_d = up_q ? pos_q + 1'b1 : pos_q - 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pos_q <= '0;
    end else begin
      pos_q <= pos_d;
    end
  end

  assign position = pos_q;
`endif

endmodule
